bin_tape_loader: RTL and testbench

//  Synthesizable replacement for bench-driven memory fill. Consumes a PDP-8 BIN-format

---
 rtl/bin_tape_loader_if.sv | 9 +
 rtl/bin_tape_loader.sv | 213 +++++++++++++++++++++
 tb/tb_bin_tape_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/bin_tape_loader_if.sv
// Byte-stream handshake between a tape byte source (UART/ROM) and the BIN loader.
interface bin_tape_loader_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/bin_tape_loader.sv
// PDP-8 BIN tape loader: decodes a BIN byte stream and replays it as timed front-panel
// Load_PC/Deposit actions, verifies the checksum, then loads START_PC and raises run.
module bin_tape_loader #(
    parameter int unsigned       WORD_W      = 12,
    parameter int unsigned       HOLD_CYCLES = 10,
    parameter logic [WORD_W-1:0] START_PC    = WORD_W'(12'o200),
    parameter bit                CHECK_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    bin_tape_loader_if.slave     bus,
    output logic [WORD_W-1:0]    sw_out,
    output logic                 load_pc,
    output logic                 deposit,
    output logic                 run,
    output logic                 busy,
    output logic                 done,
    output logic                 cksum_err,
    output logic                 fmt_err
);
    typedef enum logic [3:0] {
        S_IDLE, S_LEADER, S_HI, S_LO, S_EMIT, S_CHECK, S_LOAD_START, S_DONE, S_ERROR
    } state_t;

    localparam int unsigned      CNT_W = $clog2(3 * HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] H1    = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] H2    = CNT_W'(2 * HOLD_CYCLES);
    localparam logic [CNT_W-1:0] H3M1  = CNT_W'(3 * HOLD_CYCLES - 1);

    state_t            state, after_state;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic              strobe_next;
    logic              emit_is_load, queued_load;
    logic [WORD_W-1:0] queued_word;
    logic [7:0]        hi_byte;
    logic              hi_origin, origin_seen, pair_seen;
    logic [WORD_W-1:0] pend_word, pend_bsum, sum_prev;
    logic              pend_valid;
    logic              accept;
    logic [WORD_W-1:0] pair_word, pair_bsum;

    always_comb begin
        bus.byte_ready = (state == S_LEADER) || (state == S_HI) || (state == S_LO);
        accept         = bus.byte_valid && bus.byte_ready;
        pair_word      = WORD_W'({hi_byte[5:0], bus.byte_data[5:0]});
        pair_bsum      = WORD_W'(hi_byte) + WORD_W'(bus.byte_data);
        cnt_inc        = cnt + 1'b1;
        strobe_next    = (cnt_inc >= H1) && (cnt_inc < H2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            after_state  <= S_IDLE;
            cnt          <= '0;
            emit_is_load <= 1'b0;
            queued_load  <= 1'b0;
            queued_word  <= '0;
            hi_byte      <= '0;
            hi_origin    <= 1'b0;
            origin_seen  <= 1'b0;
            pair_seen    <= 1'b0;
            pend_word    <= '0;
            pend_bsum    <= '0;
            pend_valid   <= 1'b0;
            sum_prev     <= '0;
            sw_out       <= '0;
            load_pc      <= 1'b0;
            deposit      <= 1'b0;
            run          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cksum_err    <= 1'b0;
            fmt_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        run         <= 1'b0;
                        cksum_err   <= 1'b0;
                        fmt_err     <= 1'b0;
                        pend_valid  <= 1'b0;
                        sum_prev    <= '0;
                        origin_seen <= 1'b0;
                        pair_seen   <= 1'b0;
                        state       <= S_LEADER;
                    end
                end
                S_LEADER, S_HI: begin
                    if (accept) begin
                        if (bus.byte_data == 8'o200) begin
                            if (state == S_HI) begin
                                if (pair_seen) begin
                                    state <= S_CHECK;
                                end else begin
                                    fmt_err <= 1'b1;
                                    busy    <= 1'b0;
                                    state   <= S_ERROR;
                                end
                            end
                        end else if (bus.byte_data[7:6] == 2'b11) begin
                            state <= state;  // field frame: ignored, not summed
                        end else if (bus.byte_data[7:6] == 2'b10 ||
                                     (!bus.byte_data[6] && !origin_seen)) begin
                            fmt_err <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_ERROR;
                        end else begin
                            hi_byte   <= bus.byte_data;
                            hi_origin <= bus.byte_data[6];
                            state     <= S_LO;
                        end
                    end
                end
                S_LO: begin
                    if (accept) begin
                        if (bus.byte_data[7:6] != 2'b00) begin
                            fmt_err <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_ERROR;
                        end else begin
                            pair_seen <= 1'b1;
                            if (hi_origin) begin
                                // Pending word is flushed ahead of the origin's Load_PC.
                                origin_seen <= 1'b1;
                                after_state <= S_HI;
                                cnt         <= '0;
                                state       <= S_EMIT;
                                if (pend_valid) begin
                                    sum_prev     <= sum_prev + pair_bsum + pend_bsum;
                                    pend_valid   <= 1'b0;
                                    sw_out       <= pend_word;
                                    emit_is_load <= 1'b0;
                                    queued_load  <= 1'b1;
                                    queued_word  <= pair_word;
                                end else begin
                                    sum_prev     <= sum_prev + pair_bsum;
                                    sw_out       <= pair_word;
                                    emit_is_load <= 1'b1;
                                end
                            end else begin
                                pend_word  <= pair_word;
                                pend_bsum  <= pair_bsum;
                                pend_valid <= 1'b1;
                                if (pend_valid) begin
                                    sum_prev     <= sum_prev + pend_bsum;
                                    sw_out       <= pend_word;
                                    emit_is_load <= 1'b0;
                                    after_state  <= S_HI;
                                    cnt          <= '0;
                                    state        <= S_EMIT;
                                end else begin
                                    state <= S_HI;
                                end
                            end
                        end
                    end
                end
                S_EMIT: begin
                    cnt     <= cnt_inc;
                    load_pc <= emit_is_load && strobe_next;
                    deposit <= !emit_is_load && strobe_next;
                    if (cnt == H3M1) begin
                        if (queued_load) begin
                            queued_load  <= 1'b0;
                            sw_out       <= queued_word;
                            emit_is_load <= 1'b1;
                            cnt          <= '0;
                        end else if (after_state == S_DONE) begin
                            run   <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            state <= after_state;
                        end
                    end
                end
                S_CHECK: begin
                    if (CHECK_EN) begin
                        if (pend_valid && pend_word == sum_prev) begin
                            state <= S_LOAD_START;
                        end else begin
                            cksum_err <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_ERROR;
                        end
                    end else if (pend_valid) begin
                        pend_valid   <= 1'b0;
                        sw_out       <= pend_word;
                        emit_is_load <= 1'b0;
                        after_state  <= S_LOAD_START;
                        cnt          <= '0;
                        state        <= S_EMIT;
                    end else begin
                        state <= S_LOAD_START;
                    end
                end
                S_LOAD_START: begin
                    sw_out       <= START_PC;
                    emit_is_load <= 1'b1;
                    after_state  <= S_DONE;
                    cnt          <= '0;
                    state        <= S_EMIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_tape_loader.sv
// Scoreboard bench for bin_tape_loader: directed BIN tapes, panel strobes checked in order.
module tb_bin_tape_loader;
    localparam int unsigned HOLD = 2;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [11:0] sw_out;
    logic        load_pc, deposit, run, busy, done, cksum_err, fmt_err;

    bin_tape_loader_if bus();

    bin_tape_loader #(
        .WORD_W(12), .HOLD_CYCLES(HOLD), .START_PC(12'o200), .CHECK_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .sw_out(sw_out), .load_pc(load_pc), .deposit(deposit), .run(run),
        .busy(busy), .done(done), .cksum_err(cksum_err), .fmt_err(fmt_err)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0, n_total = 0;
    logic [12:0] exp_q[$];   // {is_load, word}
    logic [7:0]  tx[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0o expected %0o", name, act, exp);
    endtask

    // Monitor: pops one expected panel action per strobe rising edge.
    initial begin : monitor
        logic        strobe, prev;
        int unsigned width;
        logic [12:0] e;
        prev = 1'b0;
        width = 0;
        forever begin
            @(negedge clk);
            strobe = load_pc | deposit;
            if (reset) begin
                prev = 1'b0;
                width = 0;
            end else begin
                if (strobe) begin
                    chk("strobe_exclusive", 32'(load_pc & deposit), 0);
                    chk("ready_low_in_strobe", 32'(bus.byte_ready), 0);
                end
                if (strobe && !prev) begin
                    if (exp_q.size() == 0) begin
                        chk("evt_unexpected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("evt_kind_is_load", 32'(load_pc), 32'(e[12]));
                        chk("evt_sw", 32'(sw_out), 32'(e[11:0]));
                    end
                end
                if (strobe) width++;
                else if (prev) begin
                    chk("strobe_width", width, HOLD);
                    width = 0;
                end
                prev = strobe;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_flags_clear", 32'({run, done, cksum_err, fmt_err}), 0);
    endtask

    task automatic send(input bit rnd);
        int unsigned idx = 0, guard = 0;
        while (idx < tx.size() && guard < 2000) begin
            @(negedge clk);
            guard++;
            bus.byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.byte_data  = tx[idx];
            if (bus.byte_valid && bus.byte_ready) idx++;
        end
        chk("send_complete", idx, tx.size());
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_end();
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done || cksum_err || fmt_err) && n < 500);
        chk("end_reached", 32'(done | cksum_err | fmt_err), 1);
    endtask

    task automatic final_chk(input string t, input logic r, input logic d,
                             input logic ce, input logic fe);
        chk({t, "_run"}, 32'(run), 32'(r));
        chk({t, "_done"}, 32'(done), 32'(d));
        chk({t, "_cksum_err"}, 32'(cksum_err), 32'(ce));
        chk({t, "_fmt_err"}, 32'(fmt_err), 32'(fe));
        chk({t, "_busy"}, 32'(busy), 0);
        chk({t, "_events_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic push_t1();
        exp_q.push_back({1'b1, 12'o0200});
        exp_q.push_back({1'b0, 12'o0001});
        exp_q.push_back({1'b1, 12'o0200});
        tx = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o000, 8'o001, 8'o001, 8'o003, 8'o200};
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int unsigned n;
        reset = 1'b1; start = 1'b0;
        bus.byte_valid = 1'b0; bus.byte_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({sw_out, load_pc, deposit, run, busy, done, cksum_err, fmt_err}), 0);
        chk("reset_ready", 32'(bus.byte_ready), 0);
        reset = 1'b0;

        // T1: one origin, one data word, good checksum
        push_t1();
        pulse_start();
        send(1'b0);
        wait_end();
        final_chk("t1", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t1_sw_hold", 32'(sw_out), 12'o0200);

        // T2: bad checksum 0104 vs sum 0103
        exp_q.push_back({1'b1, 12'o0200});
        exp_q.push_back({1'b0, 12'o0001});
        tx = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o000, 8'o001, 8'o001, 8'o004, 8'o200};
        pulse_start();
        send(1'b0);
        wait_end();
        final_chk("t2", 1'b0, 1'b0, 1'b1, 1'b0);

        // T3: two origins; sum 0101+7+0102+5 = 0217 -> checksum bytes 002 017
        exp_q.push_back({1'b1, 12'o0100});
        exp_q.push_back({1'b0, 12'o0007});
        exp_q.push_back({1'b1, 12'o0200});
        exp_q.push_back({1'b0, 12'o0005});
        exp_q.push_back({1'b1, 12'o0200});
        tx = '{8'o200, 8'o101, 8'o000, 8'o000, 8'o007, 8'o102, 8'o000,
               8'o000, 8'o005, 8'o002, 8'o017, 8'o200};
        pulse_start();
        send(1'b0);
        wait_end();
        final_chk("t3", 1'b1, 1'b1, 1'b0, 1'b0);

        // T4: T1 tape with a field frame inserted, valid toggled randomly
        push_t1();
        tx = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o300, 8'o000, 8'o001,
               8'o001, 8'o003, 8'o200};
        pulse_start();
        send(1'b1);
        wait_end();
        final_chk("t4", 1'b1, 1'b1, 1'b0, 1'b0);

        // T5: reset lands in the middle of the deposit strobe
        exp_q.push_back({1'b1, 12'o0200});
        exp_q.push_back({1'b0, 12'o0001});
        tx = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o000, 8'o001, 8'o001, 8'o003};
        pulse_start();
        send(1'b0);
        n = 0;
        while (!deposit && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_saw_deposit", 32'(deposit), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_reset_outputs", 32'({sw_out, load_pc, deposit, run, busy, done, cksum_err, fmt_err}), 0);
        chk("t5_reset_ready", 32'(bus.byte_ready), 0);
        chk("t5_events_left", exp_q.size(), 0);
        reset = 1'b0;
        push_t1();
        pulse_start();
        send(1'b0);
        wait_end();
        final_chk("t5_restart", 1'b1, 1'b1, 1'b0, 1'b0);

        // T6: format errors
        tx = '{8'o200, 8'o000};
        pulse_start();
        send(1'b0);
        wait_end();
        final_chk("t6a", 1'b0, 1'b0, 1'b0, 1'b1);
        tx = '{8'o200, 8'o102, 8'o200};
        pulse_start();
        send(1'b0);
        wait_end();
        final_chk("t6b", 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
